// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for the NxN systolic MAC array (clear, skewed feed, drain, row readout); optional SYSTOLIC_CTRL_PERF_EN adds o_perf_cycles
module systolic_ctrl #(
  parameter int N      = 16,
  parameter int KW     = 8,
  parameter int STEP_W = 10,
  parameter int ROW_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [KW-1:0]     i_k_len,
  output logic              o_busy,
  output logic              o_zero,
  output logic [STEP_W-1:0] o_feed_step,
  output logic [N-1:0]      o_lane_en,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ROW_W-1:0]  o_out_row,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic              o_done,
  output logic [31:0]       o_perf_cycles
`else
  output logic              o_done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic                r_busy;
  logic                r_zero;
  logic [STEP_W-1:0]   r_step;
  logic [N-1:0]        r_lane_en;
  logic                r_out_valid;
  logic [ROW_W-1:0]    r_out_row;
  logic                r_done;

  logic [STEP_W-1:0]   w_k_ext;
  logic [STEP_W-1:0]   w_last_step;
  logic [STEP_W-1:0]   w_mask_step;
  logic [N-1:0]        w_mask;
  logic                w_accept;

  // K widened to the step width; the final feed step is K+2N-3 (last product at PE(N-1,N-1))
  always_comb begin
    w_k_ext     = {{(STEP_W-KW){1'b0}}, r_k};
    w_last_step = w_k_ext + STEP_W'(2*N-3);
    w_accept    = r_out_valid && i_out_ready;
  end

  // Lane mask for the step the FSM will present next cycle: lane i valid when 0 <= t-i < K
  always_comb begin
    w_mask_step = (r_state == S_FEED) ? (r_step + STEP_W'(1)) : '0;
    w_mask      = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (w_mask_step >= STEP_W'(i)) &&
                  ((w_mask_step - STEP_W'(i)) < w_k_ext);
    end
  end

  // Tile FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b0;
      r_step      <= '0;
      r_lane_en   <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_k     <= i_k_len;
            r_busy  <= 1'b1;
            r_zero  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_zero <= 1'b0;
          if (r_k != '0) begin
            r_step    <= '0;
            r_lane_en <= w_mask;
            r_state   <= S_FEED;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_FEED: begin
          if (r_step == w_last_step) begin
            r_step    <= '0;
            r_lane_en <= '0;
            r_state   <= S_DRAIN;
          end else begin
            r_step    <= r_step + STEP_W'(1);
            r_lane_en <= w_mask;
          end
        end
        S_DRAIN: begin
          r_out_valid <= 1'b1;
          r_out_row   <= '0;
          r_state     <= S_READ;
        end
        S_READ: begin
          if (w_accept) begin
            if (r_out_row == ROW_W'(N-1)) begin
              r_out_valid <= 1'b0;
              r_out_row   <= '0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_out_row <= r_out_row + ROW_W'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_zero      <= 1'b0;
          r_step      <= '0;
          r_lane_en   <= '0;
          r_out_valid <= 1'b0;
          r_out_row   <= '0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf;

  // Busy-cycle counter; the accepting cycle counts as the tile's first busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_perf <= 32'd1;
    end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf;
`endif

  assign o_busy      = r_busy;
  assign o_zero      = r_zero;
  assign o_feed_step = r_step;
  assign o_lane_en   = r_lane_en;
  assign o_out_valid = r_out_valid;
  assign o_out_row   = r_out_row;
  assign o_done      = r_done;

endmodule
